prog_divider_n: RTL and testbench
=================================

// Module: prog_divider_n
// PURPOSE
//  Programmable divide-by-N event counter; generational successor to the fixed divide-by-16 stage.
//  Counts falling edges of CLK from 0 to N-1 and emits a one-cycle terminal pulse OUT on the Nth event.
//  Adds runtime-loadable N, count enable, approx-50% square output, one-shot/periodic modes and status.
//  Sits in the SoC timing chain feeding tick-driven blocks (display refresh, debouncers, baud timing).
// PARAMETERS
//  WIDTH      5   counter/divisor width in bits; N range 2..2^WIDTH-1
//  DEFAULT_N  16  divisor after reset; must satisfy 2 <= DEFAULT_N <= 2^WIDTH-1
// PORTS
//  CLK    in   1      clock; all state updates on falling edge
//  CLEAR  in   1      asynchronous, active-low reset
//  EN     in   1      count enable; low freezes Count/SQ, forces OUT low
//  LOAD   in   1      load DIV and MODE, restart from Count=0; overrides EN and START
//  DIV    in   WIDTH  new divisor N, sampled when LOAD=1
//  MODE   in   1      0 periodic, 1 one-shot; sampled when LOAD=1
//  START  in   1      one-shot arm request; ignored in periodic mode
//  Count  out  WIDTH  current count 0..N-1
//  OUT    out  1      registered terminal pulse; high exactly while Count==N-1 in RUN
//  SQ     out  1      registered square wave; high while Count >= N-(N>>1)
//  BUSY   out  1      high in RUN
//  DONE   out  1      sticky one-shot completion flag
// BEHAVIOUR
//  - Reset (CLEAR=0, async): Count=0, OUT=0, SQ=0, BUSY=0, DONE=0, div_q=DEFAULT_N, mode_q=0, state=IDLE.
//  - Divisor clamp: DIV of 0 or 1 is stored as 2; all other values stored unchanged.
//  - States: IDLE, RUN, DONE_ST; 2-bit encoding.
//  - IDLE: Count=0. If mode_q=0 and EN=1 -> RUN; if mode_q=1 and EN=1 and START=1 -> RUN.
//    Count first increments on the edge after RUN is entered.
//  - RUN, EN=1: Count==N-2 -> Count=N-1, OUT=1. Count==N-1 -> Count=0, OUT=0.
//    Otherwise Count+1, OUT=0. One-shot: Count==N-1 -> DONE_ST, DONE=1, Count=0.
//  - RUN, EN=0: Count, SQ and state hold; OUT=0 (an OUT pulse never exceeds one cycle).
//    On EN re-assertion at Count==N-1, OUT stays 0 and Count wraps to 0; that event is dropped.
//  - DONE_ST: Count=0, OUT=0, DONE=1. START&EN -> RUN and DONE cleared; LOAD -> IDLE.
//  - LOAD (any state): next edge sets div_q=clamp(DIV), mode_q=MODE, Count=0, OUT=0, SQ=0, DONE=0, state=IDLE.
//    Periodic mode with EN=1 re-enters RUN on the following edge.
//  - SQ: registered from next Count value; for N=16 high on counts 8..15; N=5 high on 3..4.
//  - Widths: comparisons use WIDTH-bit div_q; N-1, N-2 and N>>1 are computed in WIDTH bits.
//    div_q>=2 guarantees no underflow.
//  - Simultaneous LOAD and START: LOAD wins; START is ignored.
//  - Count never exceeds div_q-1. A LOAD that shrinks N always restarts at 0, so no stale wrap.
// STRUCTURE
//  - Shared package/header prog_divider_defs.vh: state encodings (ST_IDLE=0, ST_RUN=1, ST_DONE=2).
//    Also holds the MODE_PERIODIC and MODE_ONESHOT constants.
//  - Single always block on negedge CLK / negedge CLEAR for the registers.
//  - Combinational next-state and terminal-compare logic.
//  - No sub-module warranted. Blocks are cascaded externally by feeding OUT into a downstream EN.
// TESTING
//  1. Reset defaults, EN=1 for 40 falling edges -> OUT high on edges 16 and 32 (1 cycle each).
//     Count wraps 15->0; SQ high on Count 8..15.
//  2. LOAD DIV=5 MODE=0, then EN=1 -> OUT every 5th edge, SQ pattern 0,0,0,1,1 repeating.
//  3. LOAD DIV=1 -> stored N=2: OUT toggles every edge, Count alternates 0,1.
//     LOAD DIV=0 -> identical behaviour.
//  4. LOAD DIV=4 MODE=1, START pulse -> single OUT on 4th count edge; DONE=1, BUSY=0, Count holds 0.
//     No further OUT until the next START.
//  5. Mid-count (Count=7, N=16) drop EN for 3 edges -> Count holds 7, OUT=0.
//     Resume -> OUT at Count=15, 8 enabled edges later.
//  6. CLEAR asserted asynchronously at Count=12 between edges -> all outputs reset immediately.
//     div_q returns to 16; LOAD together with START -> LOAD wins, state IDLE.

Source files
------------

// File: rtl/prog_divider_n_pkg.sv
// Shared definitions for the programmable divide-by-N event counter:
// FSM state encoding and the run-mode constants.
package prog_divider_n_pkg;

    // Controller phases. The value 3 is never reached; the FSM recovers to IDLE if it is.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // MODE input / stored mode_q meaning
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Smallest divisor the counter can hold. Smaller requests are raised to this value.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/prog_divider_n.sv
// Programmable divide-by-N event counter. It counts falling edges of CLK from 0 to N-1.
// It emits a one-cycle terminal pulse (OUT) at N-1 and a roughly 50% square wave (SQ).
// It supports periodic and one-shot operation, and reports status through BUSY and DONE.
// All state changes on the falling edge of CLK. CLEAR is an asynchronous, active-low reset.
module prog_divider_n
    import prog_divider_n_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int DEFAULT_N = 16
) (
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIV,
    input  logic             MODE,
    input  logic             START,
    output logic [WIDTH-1:0] Count,
    output logic             OUT,
    output logic             SQ,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_N);
    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q,   div_d;
    logic             mode_q,  mode_d;
    logic             out_q,   out_d;
    logic             sq_q,    sq_d;
    logic             done_q,  done_d;

    // Terminal values are derived from the stored divisor in WIDTH bits.
    // div_q is always >= 2, so none of these values can underflow.
    logic [WIDTH-1:0] n_m1;        // N-1: last count value
    logic [WIDTH-1:0] n_m2;        // N-2: the edge that raises OUT
    logic [WIDTH-1:0] sq_thr;      // SQ is high on counts >= N - (N>>1)
    logic [WIDTH-1:0] div_clamped; // DIV with 0/1 raised to the minimum divisor
    logic             at_last;
    logic             at_pen;

    // Terminal-compare and divisor-clamp helpers
    always_comb begin
        n_m1        = div_q - WIDTH'(1);
        n_m2        = div_q - WIDTH'(2);
        sq_thr      = div_q - (div_q >> 1);
        at_last     = (count_q == n_m1);
        at_pen      = (count_q == n_m2);
        div_clamped = (DIV < MIN_DIV_W) ? MIN_DIV_W : DIV;
    end

    // Next-state logic. LOAD takes priority over EN and START in every state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        mode_d  = mode_q;
        done_d  = done_q;
        out_d   = 1'b0;

        if (LOAD) begin
            div_d   = div_clamped;
            mode_d  = MODE;
            count_d = '0;
            done_d  = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (EN && (mode_q == MODE_PERIODIC || START)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // When EN is low, the count and the state hold and OUT drops.
                    // If EN returns while the count sits at N-1, the count wraps
                    // without a pulse, so that event is lost.
                    if (EN) begin
                        if (at_last) begin
                            count_d = '0;
                            if (mode_q == MODE_ONESHOT) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else if (at_pen) begin
                            count_d = n_m1;
                            out_d   = 1'b1;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                    done_d  = 1'b1;
                    if (START && EN) begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // SQ follows the next count, so it stays aligned with Count after the edge.
        // Under LOAD the next count is 0, which would also give 0. The explicit
        // override makes that intent clear.
        sq_d = LOAD ? 1'b0 : (count_d >= sq_thr);
    end

    // State register. It updates on the falling edge of CLK and clears asynchronously on CLEAR.
    always_ff @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            div_q   <= RST_DIV;
            mode_q  <= MODE_PERIODIC;
            out_q   <= 1'b0;
            sq_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            sq_q    <= sq_d;
            done_q  <= done_d;
        end
    end

    assign Count = count_q;
    assign OUT   = out_q;
    assign SQ    = sq_q;
    assign DONE  = done_q;
    assign BUSY  = (state_q == ST_RUN);

endmodule

// File: tb/tb_prog_divider_n.sv
// Directed and randomized bench for prog_divider_n. A behavioural model tracks the
// divider as "N, phase, event count". Each falling edge is checked against the model.
module tb_prog_divider_n;

    localparam int W = 5;

    logic         CLK;
    logic         CLEAR;
    logic         EN;
    logic         LOAD;
    logic [W-1:0] DIV;
    logic         MODE;
    logic         START;
    logic [W-1:0] Count;
    logic         OUT;
    logic         SQ;
    logic         BUSY;
    logic         DONE;

    prog_divider_n #(.WIDTH(W), .DEFAULT_N(16)) dut (
        .CLK   (CLK),
        .CLEAR (CLEAR),
        .EN    (EN),
        .LOAD  (LOAD),
        .DIV   (DIV),
        .MODE  (MODE),
        .START (START),
        .Count (Count),
        .OUT   (OUT),
        .SQ    (SQ),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: phase 0 idle, 1 running, 2 finished one-shot
    int m_n, m_cnt, m_ph;
    bit m_os, m_out, m_sq, m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 16; m_cnt = 0; m_ph = 0; m_os = 0; m_out = 0; m_sq = 0; m_done = 0;
    endtask

    // Advance the model by one falling edge, given the inputs that were applied at that edge.
    task automatic model_edge(input bit en, input bit load, input bit start,
                              input bit mode, input int div);
        int prev_ph;
        prev_ph = m_ph;
        if (load) begin
            m_n = (div < 2) ? 2 : div;
            m_os = mode; m_ph = 0; m_cnt = 0; m_done = 0;
        end else if (m_ph == 0) begin
            m_cnt = 0;
            if (en && (!m_os || start)) m_ph = 1;
        end else if (m_ph == 1) begin
            if (en) begin
                if (m_os && m_cnt == m_n - 1) begin
                    m_ph = 2; m_done = 1; m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % m_n;
                end
            end
        end else begin
            m_cnt = 0;
            if (en && start) begin m_ph = 1; m_done = 0; end
        end
        // A pulse marks an enabled RUN edge that lands on the last count.
        m_out = !load && en && prev_ph == 1 && m_ph == 1 && m_cnt == m_n - 1;
        m_sq  = m_cnt >= m_n - m_n / 2;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Count"}, 32'(Count), 32'(m_cnt));
        chk({tag, ".OUT"},   32'(OUT),   32'(m_out));
        chk({tag, ".SQ"},    32'(SQ),    32'(m_sq));
        chk({tag, ".BUSY"},  32'(BUSY),  32'(m_ph == 1));
        chk({tag, ".DONE"},  32'(DONE),  32'(m_done));
    endtask

    // Apply the inputs, take one falling edge, then compare the outputs just after it.
    task automatic step(input string tag, input bit en, input bit load, input bit start,
                        input bit mode, input int div);
        EN = en; LOAD = load; START = start; MODE = mode; DIV = W'(div);
        @(negedge CLK);
        #1;
        model_edge(en, load, start, mode, div);
        check_all(tag);
        if (OUT === 1'b1) pulses++;
    endtask

    initial begin
        CLEAR = 1'b0; EN = 0; LOAD = 0; DIV = '0; MODE = 0; START = 0;
        model_reset();
        #12;
        check_all("reset");
        CLEAR = 1'b1;

        // 1: default N=16, free-running for 40 edges
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            step("t1", 1, 0, 0, 0, 0);
            if (i == 16 || i == 32) chk("t1.pulse_edge", 32'(OUT), 32'd1);
        end
        chk("t1.pulse_count", 32'(pulses), 32'd2);

        // 2: N=5 periodic
        step("t2.load", 1, 1, 0, 0, 5);
        pulses = 0;
        for (int i = 0; i < 16; i++) step("t2", 1, 0, 0, 0, 0);
        chk("t2.pulse_count", 32'(pulses), 32'd3);

        // 3: DIV=1 and DIV=0 both behave as N=2
        step("t3.load1", 1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) step("t3.n1", 1, 0, 0, 0, 0);
        step("t3.load0", 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("t3.n0", 1, 0, 0, 0, 0);

        // 4: one-shot N=4 waits for START, fires once, then parks in DONE
        step("t4.load", 1, 1, 0, 1, 4);
        for (int i = 0; i < 3; i++) step("t4.wait", 1, 0, 0, 0, 0);
        chk("t4.idle_busy", 32'(BUSY), 32'd0);
        step("t4.start", 1, 0, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) step("t4.run", 1, 0, 0, 0, 0);
        chk("t4.pulse_count", 32'(pulses), 32'd1);
        chk("t4.done", 32'(DONE), 32'd1);

        // 5: N=16, freeze at Count=7 for 3 edges, then resume
        step("t5.load", 1, 1, 0, 0, 16);
        for (int i = 0; i < 8; i++) step("t5.pre", 1, 0, 0, 0, 0);
        chk("t5.at7", 32'(Count), 32'd7);
        for (int i = 0; i < 3; i++) step("t5.hold", 0, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) step("t5.resume", 1, 0, 0, 0, 0);
        chk("t5.out_at15", 32'(OUT), 32'd1);
        chk("t5.one_pulse", 32'(pulses), 32'd1);

        // 6: asynchronous clear mid-cycle at Count=12
        step("t6.load", 1, 1, 0, 0, 9);
        step("t6.load", 1, 1, 0, 0, 16);
        for (int i = 0; i < 13; i++) step("t6.pre", 1, 0, 0, 0, 0);
        chk("t6.at12", 32'(Count), 32'd12);
        #2 CLEAR = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        #2 CLEAR = 1'b1;
        // After the clear the divisor is back to 16, so the pulse comes on the 16th edge.
        for (int i = 0; i < 16; i++) step("t6.n16", 1, 0, 0, 0, 0);
        chk("t6.default_out", 32'(OUT), 32'd1);
        step("t6.load_start", 1, 1, 1, 1, 7);
        chk("t6.load_wins", 32'(BUSY), 32'd0);
        for (int i = 0; i < 4; i++) step("t6.after", 1, 0, 0, 0, 0);

        // Randomized stimulus
        for (int i = 0; i < 600; i++) begin
            bit r_load, r_en, r_start, r_mode;
            int r_div;
            r_load  = ($urandom_range(0, 29) == 0);
            r_en    = ($urandom_range(0, 99) < 85);
            r_start = ($urandom_range(0, 99) < 20);
            r_mode  = 1'($urandom_range(0, 1));
            r_div   = int'($urandom_range(0, 31));
            step("rand", r_en, r_load, r_start, r_mode, r_div);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
